// File: rtl/prbs_grant_scheduler.sv
// prbs_grant_scheduler
// Shares one 5-bit maximal-length LFSR (x^5+x^3+1) between NREQ requesters.
// Round-robin arbitration hands the current LFSR word to the winner and
// advances the LFSR. An IDLE/LOAD/RUN FSM sequences seeding, and a pulse
// marks every grant that completes a full 31-step period.

module prbs_grant_scheduler #(
  parameter int NREQ = 4,
  parameter logic [4:0] SEED = 5'b10000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            seed_load,
  input  logic [4:0]      seed,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [4:0]      rnd_out,
  output logic            rnd_valid,
  output logic            period_pulse,
  output logic [1:0]      state_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [4:0]      lfsr;
  logic [4:0]      lfsr_next;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_next;
  logic [PW-1:0]   winner;
  logic [4:0]      step_cnt;
  logic [NREQ-1:0] eff_req;
  logic            found;
  logic            grant_fire;
  int              idx;
  int              nxt;

  assign state_o = state;

  // A requester that is being granted right now cannot win again on this edge,
  // so it has time to drop its request after seeing gnt.
  assign eff_req   = req & ~gnt;
  assign lfsr_next = {lfsr[3:0], lfsr[4] ^ lfsr[2]};

  // A grant happens only in steady RUN with no seed load pending.
  assign grant_fire = (state == RUN) && en && !seed_load && (eff_req != '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a seed load overrides everything else.
  always_comb begin
    state_next = state;
    if (seed_load) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE:    if (en) state_next = RUN;
        LOAD:    state_next = en ? RUN : IDLE;
        RUN:     if (!en) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Round-robin search starting at ptr, plus the pointer value after the win.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    nxt      = 0;
    ptr_next = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eff_req[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
    nxt = int'(winner) + 1;
    if (nxt >= NREQ) nxt = 0;
    ptr_next = nxt[PW-1:0];
  end

  // Datapath: seeding, grant issue, LFSR advance and period counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr         <= SEED;
      ptr          <= '0;
      step_cnt     <= '0;
      gnt          <= '0;
      rnd_out      <= '0;
      rnd_valid    <= 1'b0;
      period_pulse <= 1'b0;
    end else begin
      gnt          <= '0;
      rnd_valid    <= 1'b0;
      period_pulse <= 1'b0;
      if (seed_load) begin
        lfsr     <= (seed == 5'd0) ? SEED : seed;
        step_cnt <= '0;
      end else if (grant_fire) begin
        gnt          <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
        rnd_out      <= lfsr;
        rnd_valid    <= 1'b1;
        lfsr         <= lfsr_next;
        ptr          <= ptr_next;
        step_cnt     <= (step_cnt == 5'd30) ? 5'd0 : step_cnt + 5'd1;
        period_pulse <= (step_cnt == 5'd30);
      end
    end
  end

endmodule

// File: tb/tb_prbs_grant_scheduler.sv
// tb_prbs_grant_scheduler
// Directed bench for the PRBS grant scheduler: reset values, single and
// rotating requesters, en gating, seed loading, period wrap and reset mid-grant.

module tb_prbs_grant_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic       seed_load;
  logic [4:0] seed;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [4:0] rnd_out;
  logic       rnd_valid;
  logic       period_pulse;
  logic [1:0] state_o;

  int checks;
  int failures;

  logic [3:0] t2_gnt [4];
  logic [4:0] t2_rnd [4];
  logic [4:0] exp_rnd;
  int         exp_idx;

  prbs_grant_scheduler #(.NREQ(4), .SEED(5'b10000)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .seed_load    (seed_load),
    .seed         (seed),
    .req          (req),
    .gnt          (gnt),
    .rnd_out      (rnd_out),
    .rnd_valid    (rnd_valid),
    .period_pulse (period_pulse),
    .state_o      (state_o)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] lfsr_step(input logic [4:0] v);
    return {v[3:0], v[4] ^ v[2]};
  endfunction

  task automatic applyStimulus(input logic e, input logic sl,
                               input logic [4:0] s, input logic [3:0] r);
    en        = e;
    seed_load = sl;
    seed      = s;
    req       = r;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    t2_gnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t2_rnd = '{5'b00100, 5'b01001, 5'b10010, 5'b00101};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, 4'b0000);
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt",    32'(gnt), 32'h0);
    checkOutput("rst_rnd",    32'(rnd_out), 32'h0);
    checkOutput("rst_valid",  32'(rnd_valid), 32'h0);
    checkOutput("rst_period", 32'(period_pulse), 32'h0);
    checkOutput("rst_state",  32'(state_o), 32'd0);
    rst = 1'b0;

    // Single requester: grant every other cycle, LFSR walks from the seed.
    $display("[TB] single requester");
    applyStimulus(1'b1, 1'b0, 5'd0, 4'b0001);
    tick();
    checkOutput("t1_state_run", 32'(state_o), 32'd2);
    checkOutput("t1_no_gnt_on_entry", 32'(gnt), 32'h0);
    tick();
    checkOutput("t1_gnt_a", 32'(gnt), 32'b0001);
    checkOutput("t1_rnd_a", 32'(rnd_out), 32'b10000);
    checkOutput("t1_valid_a", 32'(rnd_valid), 32'h1);
    tick();
    checkOutput("t1_gap_gnt", 32'(gnt), 32'h0);
    checkOutput("t1_gap_valid", 32'(rnd_valid), 32'h0);
    checkOutput("t1_gap_hold", 32'(rnd_out), 32'b10000);
    tick();
    checkOutput("t1_gnt_b", 32'(gnt), 32'b0001);
    checkOutput("t1_rnd_b", 32'(rnd_out), 32'b00001);
    tick();
    checkOutput("t1_gap2_gnt", 32'(gnt), 32'h0);
    tick();
    checkOutput("t1_gnt_c", 32'(gnt), 32'b0001);
    checkOutput("t1_rnd_c", 32'(rnd_out), 32'b00010);

    // All requesters: rotation starts after requester 0, one grant per cycle.
    $display("[TB] round robin");
    applyStimulus(1'b1, 1'b0, 5'd0, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t2_gnt_%0d", i), 32'(gnt), 32'(t2_gnt[i]));
      checkOutput($sformatf("t2_rnd_%0d", i), 32'(rnd_out), 32'(t2_rnd[i]));
    end

    // en low parks in IDLE; resuming continues from the held lfsr and ptr.
    $display("[TB] enable gating");
    applyStimulus(1'b0, 1'b0, 5'd0, 4'b1111);
    tick();
    checkOutput("t5_stop_gnt", 32'(gnt), 32'h0);
    checkOutput("t5_stop_state", 32'(state_o), 32'd0);
    checkOutput("t5_stop_hold", 32'(rnd_out), 32'b00101);
    tick();
    checkOutput("t5_idle_gnt", 32'(gnt), 32'h0);
    applyStimulus(1'b1, 1'b0, 5'd0, 4'b1111);
    tick();
    checkOutput("t5_resume_state", 32'(state_o), 32'd2);
    checkOutput("t5_resume_nognt", 32'(gnt), 32'h0);
    tick();
    checkOutput("t5_resume_gnt", 32'(gnt), 32'b0010);
    checkOutput("t5_resume_rnd", 32'(rnd_out), 32'b01011);

    // Zero seed falls back to SEED; load blocks the grant on its edge.
    $display("[TB] zero seed load");
    applyStimulus(1'b1, 1'b1, 5'b00000, 4'b1111);
    tick();
    checkOutput("t4_load_gnt", 32'(gnt), 32'h0);
    checkOutput("t4_load_state", 32'(state_o), 32'd1);
    checkOutput("t4_load_hold", 32'(rnd_out), 32'b01011);
    applyStimulus(1'b1, 1'b0, 5'd0, 4'b1111);
    tick();
    checkOutput("t4_load_to_run", 32'(state_o), 32'd2);
    checkOutput("t4_run_nognt", 32'(gnt), 32'h0);

    // Full period: pulse only on the 31st grant, then the sequence repeats.
    $display("[TB] period");
    exp_rnd = 5'b10000;
    exp_idx = 2;
    for (int k = 1; k <= 32; k++) begin
      tick();
      checkOutput($sformatf("t3_gnt_%0d", k), 32'(gnt), 32'(4'b0001 << exp_idx));
      checkOutput($sformatf("t3_rnd_%0d", k), 32'(rnd_out), 32'(exp_rnd));
      checkOutput($sformatf("t3_period_%0d", k), 32'(period_pulse), (k == 31) ? 32'h1 : 32'h0);
      exp_rnd = lfsr_step(exp_rnd);
      exp_idx = (exp_idx + 1) % 4;
    end
    checkOutput("t3_wrap", 32'(rnd_out), 32'b10000);

    // Non-zero seed is used as-is.
    $display("[TB] explicit seed");
    applyStimulus(1'b1, 1'b1, 5'b00111, 4'b1111);
    tick();
    checkOutput("t4b_load_state", 32'(state_o), 32'd1);
    checkOutput("t4b_load_gnt", 32'(gnt), 32'h0);
    applyStimulus(1'b1, 1'b0, 5'd0, 4'b1111);
    tick();
    checkOutput("t4b_run_state", 32'(state_o), 32'd2);
    tick();
    checkOutput("t4b_gnt_a", 32'(gnt), 32'b0100);
    checkOutput("t4b_rnd_a", 32'(rnd_out), 32'b00111);
    checkOutput("t4b_period_a", 32'(period_pulse), 32'h0);
    tick();
    checkOutput("t4b_gnt_b", 32'(gnt), 32'b1000);
    checkOutput("t4b_rnd_b", 32'(rnd_out), 32'b01111);

    // Reset while a grant is showing clears everything without a clock edge.
    $display("[TB] reset mid-grant");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_gnt", 32'(gnt), 32'h0);
    checkOutput("t6_valid", 32'(rnd_valid), 32'h0);
    checkOutput("t6_rnd", 32'(rnd_out), 32'h0);
    checkOutput("t6_period", 32'(period_pulse), 32'h0);
    checkOutput("t6_state", 32'(state_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 5'd0, 4'b1111);
    tick();
    checkOutput("t6_rerun_state", 32'(state_o), 32'd2);
    tick();
    checkOutput("t6_rerun_gnt", 32'(gnt), 32'b0001);
    checkOutput("t6_rerun_rnd", 32'(rnd_out), 32'b10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
